aw_arbiter: RTL and testbench

- Write-path arbiter for the two-master AXI interconnect. It chooses between the M0 and M1 write-address requests and drives the one-hot grant into the AW channel mux and the W channel mux.
- Once a master is granted, the grant stays locked for the whole write transaction: AW handshake, W burst up to WLAST and, optionally, the B response. Only then can the other master win.
- Round-robin fairness between the two masters.

---
 rtl/axi_pkg.sv | 36 +++
 rtl/rr_pick2.sv | 27 ++
 rtl/aw_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_aw_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the two-master AXI interconnect:
//   - bus width constants used by the muxes and slave ports
//   - one-hot grant encodings shared by the AW and AR arbiters
//   - arbiter state enum
//   - watchdog counter width helper
// -----------------------------------------------------------------------------
package axi_pkg;

  // Bus widths of the interconnect data path.
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  // One-hot grant encodings: bit 0 selects M0, bit 1 selects M1.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // The watchdog counter is at least 8 bits wide so that a disabled watchdog
  // (limit 0) still gets a legal, saturating counter.
  function automatic int wd_width(input int unsigned max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin chooser, shared by the AW and AR arbiters.
// Ports:
//   req    [1:0] in   request vector, bit 0 = M0, bit 1 = M1
//   last   [1:0] in   one-hot master that won the previous arbitration
//   winner [1:0] out  one-hot winner, GNT_NONE when nobody requests
// -----------------------------------------------------------------------------
module rr_pick2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner
);

  always_comb begin
    case (req)
      2'b01:   winner = GNT_M0;
      2'b10:   winner = GNT_M1;
      // On a tie the master that did not win last time gets the bus.
      2'b11:   winner = (last == GNT_M0) ? GNT_M1 : GNT_M0;
      default: winner = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/aw_arbiter.sv
// -----------------------------------------------------------------------------
// aw_arbiter
// Write-path arbiter for the two-master AXI interconnect. Grants one master at
// a time and keeps the grant locked for the whole write transaction (AW
// handshake, W burst up to WLAST and, with WAIT_B=1, the B handshake).
// Parameters:
//   WAIT_B    1: hold grant until B handshake; 0: release after AW + W-last
//   MAX_WAIT  watchdog limit in cycles per transaction; 0 disables it
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   AWVALID_M0/M1           per-master write-address requests
//   AWVALID, AWREADY        muxed AW handshake
//   WVALID, WREADY, WLAST   muxed W handshake
//   BVALID, BREADY          B handshake
//   gnt, wgnt               registered one-hot AW / W mux selects
//   AWREADY_M0/M1           AWREADY routed to the granted master
//   busy                    transaction in flight
//   timeout                 one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module aw_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned WAIT_B   = 1,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       AWVALID_M0,
  input  logic       AWVALID_M1,
  input  logic       AWVALID,
  input  logic       AWREADY,
  input  logic       WVALID,
  input  logic       WREADY,
  input  logic       WLAST,
  input  logic       BVALID,
  input  logic       BREADY,
  output logic [1:0] gnt,
  output logic [1:0] wgnt,
  output logic       AWREADY_M0,
  output logic       AWREADY_M1,
  output logic       busy,
  output logic       timeout
);

  localparam int             CNT_W    = wd_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_WAIT);

  arb_state_t       r_state,    w_state_nxt;
  logic [1:0]       r_gnt,      w_gnt_nxt;
  logic [1:0]       r_wgnt,     w_wgnt_nxt;
  logic [1:0]       r_last_gnt, w_last_gnt_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_timeout,  w_timeout_nxt;
  logic             r_aw_done,  w_aw_done_nxt;
  logic             r_w_done,   w_w_done_nxt;
  logic [CNT_W-1:0] r_wd_cnt,   w_wd_cnt_nxt;

  logic [1:0]       w_winner;
  logic             w_aw_sat;
  logic             w_w_sat;
  logic [CNT_W-1:0] w_wd_inc;
  logic             w_wd_fire;

  rr_pick2 u_pick (
    .req    ({AWVALID_M1, AWVALID_M0}),
    .last   (r_last_gnt),
    .winner (w_winner)
  );

  // Each phase counts as complete if it finished earlier or completes now,
  // so AW and W may finish in either order or in the same cycle.
  assign w_aw_sat = r_aw_done | (AWVALID & AWREADY);
  assign w_w_sat  = r_w_done  | (WVALID & WREADY & WLAST);

  // Saturating increment: the counter never wraps, even with the watchdog off.
  assign w_wd_inc  = (r_wd_cnt == CNT_MAX) ? r_wd_cnt : r_wd_cnt + CNT_W'(1);
  assign w_wd_fire = (MAX_WAIT != 0) && (w_wd_inc == WD_LIMIT);

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_wgnt_nxt     = r_wgnt;
    w_last_gnt_nxt = r_last_gnt;
    w_busy_nxt     = r_busy;
    w_timeout_nxt  = 1'b0;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_wd_cnt_nxt   = r_wd_cnt;

    case (r_state)
      IDLE: begin
        w_gnt_nxt  = GNT_NONE;
        w_wgnt_nxt = GNT_NONE;
        w_busy_nxt = 1'b0;
        if (w_winner != GNT_NONE) begin
          w_state_nxt    = XFER;
          w_gnt_nxt      = w_winner;
          w_wgnt_nxt     = w_winner;
          w_last_gnt_nxt = w_winner;
          w_busy_nxt     = 1'b1;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wd_cnt_nxt   = '0;
        end
      end

      XFER: begin
        w_wd_cnt_nxt = w_wd_inc;
        if (w_aw_sat && w_w_sat) begin
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_wgnt_nxt    = GNT_NONE;
          if (WAIT_B != 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = GNT_NONE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_aw_done_nxt = w_aw_sat;
          w_w_done_nxt  = w_w_sat;
        end
      end

      RESP: begin
        w_wd_cnt_nxt = w_wd_inc;
        if (BVALID && BREADY) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = GNT_NONE;
          w_busy_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = GNT_NONE;
        w_wgnt_nxt  = GNT_NONE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Watchdog abort only when the transaction made no state progress this
    // cycle; a legitimate completion on the limit cycle takes precedence.
    // last_gnt is kept so the other master wins the next tie.
    if (w_wd_fire && (r_state != IDLE) && (w_state_nxt == r_state)) begin
      w_state_nxt   = IDLE;
      w_gnt_nxt     = GNT_NONE;
      w_wgnt_nxt    = GNT_NONE;
      w_busy_nxt    = 1'b0;
      w_timeout_nxt = 1'b1;
      w_aw_done_nxt = 1'b0;
      w_w_done_nxt  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= IDLE;
      r_gnt      <= GNT_NONE;
      r_wgnt     <= GNT_NONE;
      r_last_gnt <= GNT_M1;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_wd_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_wgnt     <= w_wgnt_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_wd_cnt   <= w_wd_cnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign wgnt    = r_wgnt;
  assign busy    = r_busy;
  assign timeout = r_timeout;

  // AWREADY reaches only the granted master and only until its AW handshake,
  // which blocks a second address phase inside a locked transaction.
  assign AWREADY_M0 = AWREADY & r_gnt[0] & (r_state == XFER) & ~r_aw_done;
  assign AWREADY_M1 = AWREADY & r_gnt[1] & (r_state == XFER) & ~r_aw_done;

endmodule

// File: tb/tb_aw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aw_arbiter
// Directed bench for aw_arbiter. Three instances share the stimulus:
//   u_a  default parameters (WAIT_B=1, MAX_WAIT=255)
//   u_b  WAIT_B=0
//   u_c  MAX_WAIT=16
// Each scenario resets all instances and checks the instance it targets.
// -----------------------------------------------------------------------------
module tb_aw_arbiter;

  logic ACLK;
  logic ARESET;
  logic AWVALID_M0, AWVALID_M1, AWVALID, AWREADY;
  logic WVALID, WREADY, WLAST, BVALID, BREADY;

  logic [1:0] a_gnt, a_wgnt, b_gnt, b_wgnt, c_gnt, c_wgnt;
  logic       a_awr_m0, a_awr_m1, a_busy, a_timeout;
  logic       b_awr_m0, b_awr_m1, b_busy, b_timeout;
  logic       c_awr_m0, c_awr_m1, c_busy, c_timeout;

  int n_checks = 0;
  int n_errors = 0;

  aw_arbiter u_a (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .gnt(a_gnt), .wgnt(a_wgnt),
    .AWREADY_M0(a_awr_m0), .AWREADY_M1(a_awr_m1),
    .busy(a_busy), .timeout(a_timeout)
  );

  aw_arbiter #(.WAIT_B(0)) u_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .gnt(b_gnt), .wgnt(b_wgnt),
    .AWREADY_M0(b_awr_m0), .AWREADY_M1(b_awr_m1),
    .busy(b_busy), .timeout(b_timeout)
  );

  aw_arbiter #(.MAX_WAIT(16)) u_c (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .gnt(c_gnt), .wgnt(c_wgnt),
    .AWREADY_M0(c_awr_m0), .AWREADY_M1(c_awr_m1),
    .busy(c_busy), .timeout(c_timeout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_bus;
    AWVALID = 1'b0; AWREADY = 1'b0;
    WVALID  = 1'b0; WREADY  = 1'b0; WLAST = 1'b0;
    BVALID  = 1'b0; BREADY  = 1'b0;
  endtask

  task automatic do_reset;
    ARESET = 1'b1;
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
    clear_bus();
    tick();
    ARESET = 1'b0;
  endtask

  // One full transaction on u_a with AW and W-last in the same cycle,
  // starting from an IDLE cycle with requests already asserted.
  task automatic xfer_rr(input logic [1:0] exp, input int idx);
    tick();
    check($sformatf("rr%0d_gnt", idx), a_gnt, exp);
    check($sformatf("rr%0d_busy", idx), 2'(a_busy), 2'b01);
    AWVALID = 1'b1; AWREADY = 1'b1;
    WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b1;
    #1;
    check($sformatf("rr%0d_awready", idx), {a_awr_m1, a_awr_m0}, exp);
    tick();
    clear_bus();
    check($sformatf("rr%0d_resp_wgnt", idx), a_wgnt, 2'b00);
    check($sformatf("rr%0d_resp_gnt", idx), a_gnt, exp);
    BVALID = 1'b1; BREADY = 1'b1;
    tick();
    BVALID = 1'b0; BREADY = 1'b0;
    check($sformatf("rr%0d_idle_gnt", idx), a_gnt, 2'b00);
    check($sformatf("rr%0d_idle_busy", idx), 2'(a_busy), 2'b00);
  endtask

  initial begin
    ARESET = 1'b1;
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
    clear_bus();
    tick();
    tick();

    // Reset state
    check("rst_gnt",     a_gnt, 2'b00);
    check("rst_wgnt",    a_wgnt, 2'b00);
    check("rst_busy",    2'(a_busy), 2'b00);
    check("rst_timeout", 2'(a_timeout), 2'b00);
    check("rst_b_gnt",   b_gnt, 2'b00);
    check("rst_c_gnt",   c_gnt, 2'b00);

    // 1: single M0 transaction, AW in cycle 3, WLAST in cycle 5, B in cycle 7
    ARESET = 1'b0;
    AWVALID_M0 = 1'b1;                       // cycle 1
    tick();                                  // cycle 2
    check("t1_gnt",  a_gnt, 2'b01);
    check("t1_wgnt", a_wgnt, 2'b01);
    check("t1_busy", 2'(a_busy), 2'b01);
    AWVALID = 1'b1;
    #1;
    check("t1_awr_wait", {a_awr_m1, a_awr_m0}, 2'b00);
    tick();                                  // cycle 3
    AWREADY = 1'b1;
    #1;
    check("t1_awr_hs", {a_awr_m1, a_awr_m0}, 2'b01);
    tick();                                  // cycle 4
    AWVALID = 1'b0; AWVALID_M0 = 1'b0;
    WVALID = 1'b1; WREADY = 1'b1;
    #1;
    check("t1_awr_after", {a_awr_m1, a_awr_m0}, 2'b00);
    tick();                                  // cycle 5
    AWREADY = 1'b0; WLAST = 1'b1;
    check("t1_wgnt_burst", a_wgnt, 2'b01);
    tick();                                  // cycle 6
    WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    check("t1_resp_wgnt", a_wgnt, 2'b00);
    check("t1_resp_gnt",  a_gnt, 2'b01);
    check("t1_resp_busy", 2'(a_busy), 2'b01);
    tick();                                  // cycle 7
    BVALID = 1'b1; BREADY = 1'b1;
    check("t1_hold_gnt", a_gnt, 2'b01);
    tick();                                  // cycle 8
    BVALID = 1'b0; BREADY = 1'b0;
    check("t1_end_gnt",  a_gnt, 2'b00);
    check("t1_end_busy", 2'(a_busy), 2'b00);

    // 2: both masters requesting continuously -> alternating grants
    do_reset();
    AWVALID_M0 = 1'b1; AWVALID_M1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer_rr((i % 2 == 0) ? 2'b01 : 2'b10, i);
    end
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;

    // 3: W-last before AW
    do_reset();
    AWVALID_M0 = 1'b1;
    tick();                                  // XFER cycle 1
    check("t3_gnt", a_gnt, 2'b01);
    tick();                                  // XFER cycle 2
    WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b1;
    tick();                                  // XFER cycle 3
    WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    check("t3_wgnt_hold", a_wgnt, 2'b01);
    tick();                                  // XFER cycle 4
    AWVALID = 1'b1; AWREADY = 1'b1;
    #1;
    check("t3_awr_hs", {a_awr_m1, a_awr_m0}, 2'b01);
    tick();                                  // RESP
    AWVALID = 1'b0; AWVALID_M0 = 1'b0;
    check("t3_wgnt_clr", a_wgnt, 2'b00);
    check("t3_gnt_hold", a_gnt, 2'b01);
    #1;
    check("t3_awr_after", {a_awr_m1, a_awr_m0}, 2'b00);
    BVALID = 1'b1; BREADY = 1'b1;
    tick();
    clear_bus();
    check("t3_end_gnt", a_gnt, 2'b00);

    // 4: WAIT_B=0, AW and W-last in the same cycle
    do_reset();
    AWVALID_M0 = 1'b1;
    tick();
    check("t4_gnt", b_gnt, 2'b01);
    AWVALID = 1'b1; AWREADY = 1'b1;
    WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b1;
    tick();
    clear_bus();
    AWVALID_M0 = 1'b0;
    check("t4_end_gnt",  b_gnt, 2'b00);
    check("t4_end_wgnt", b_wgnt, 2'b00);
    check("t4_end_busy", 2'(b_busy), 2'b00);

    // 5: MAX_WAIT=16, M1 granted, WLAST never comes, M0 pending
    do_reset();
    AWVALID_M1 = 1'b1;
    tick();                                  // XFER cycle 1
    check("t5_gnt", c_gnt, 2'b10);
    AWVALID = 1'b1; AWREADY = 1'b1; AWVALID_M0 = 1'b1;
    tick();                                  // XFER cycle 2
    AWVALID = 1'b0; AWREADY = 1'b0;
    check("t5_hold_gnt_2", c_gnt, 2'b10);
    for (int i = 3; i <= 16; i++) begin
      tick();                                // XFER cycle i
      check($sformatf("t5_hold_gnt_%0d", i), c_gnt, 2'b10);
      check($sformatf("t5_no_to_%0d", i), 2'(c_timeout), 2'b00);
    end
    tick();
    check("t5_timeout", 2'(c_timeout), 2'b01);
    check("t5_to_gnt",  c_gnt, 2'b00);
    check("t5_to_busy", 2'(c_busy), 2'b00);
    tick();
    check("t5_pulse_end", 2'(c_timeout), 2'b00);
    check("t5_regrant",   c_gnt, 2'b01);
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;

    // 6: reset in RESP with M1 granted, then a tie goes to M0
    do_reset();
    AWVALID_M1 = 1'b1;
    tick();
    check("t6_gnt", a_gnt, 2'b10);
    AWVALID = 1'b1; AWREADY = 1'b1;
    WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b1;
    tick();
    clear_bus();
    AWVALID_M1 = 1'b0;
    check("t6_resp_gnt",  a_gnt, 2'b10);
    check("t6_resp_wgnt", a_wgnt, 2'b00);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check("t6_rst_gnt",  a_gnt, 2'b00);
    check("t6_rst_wgnt", a_wgnt, 2'b00);
    check("t6_rst_busy", 2'(a_busy), 2'b00);
    AWVALID_M0 = 1'b1; AWVALID_M1 = 1'b1;
    tick();
    check("t6_tie_gnt", a_gnt, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
